// File: rtl/booth_pkg.sv
// Shared types and constants for the shared Booth multiplier.
package booth_pkg;

  typedef logic [1:0] state_t;

  localparam state_t StIdle = 2'd0;
  localparam state_t StRun  = 2'd1;
  localparam state_t StDone = 2'd2;

  // {Q[0], Q_1} recoding pairs
  localparam logic [1:0] BOOTH_SUB = 2'b10;
  localparam logic [1:0] BOOTH_ADD = 2'b01;

endpackage

// File: rtl/booth_core.sv
// Sequential radix-2 Booth datapath: one add/sub-and-shift step per cycle.
module booth_core
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               load,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               step,
  output logic               last,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  // acc is one bit wider than the operands so -M never overflows
  logic [WIDTH:0]   acc_q, acc_sum, m_q;
  logic [WIDTH-1:0] q_q;
  logic             q1_q;
  logic [CW-1:0]    cnt_q;

  // Booth recoding of the current multiplier pair
  always_comb begin
    acc_sum = acc_q;
    case ({q_q[0], q1_q})
      BOOTH_SUB: acc_sum = acc_q - m_q;
      BOOTH_ADD: acc_sum = acc_q + m_q;
      default:   acc_sum = acc_q;
    endcase
  end

  // Load operands, or apply one step followed by an arithmetic right shift
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      acc_q <= '0;
      q_q   <= '0;
      q1_q  <= 1'b0;
      m_q   <= '0;
      cnt_q <= '0;
    end else if (load) begin
      acc_q <= '0;
      q_q   <= a;
      q1_q  <= 1'b0;
      m_q   <= {b[WIDTH-1], b};
      cnt_q <= '0;
    end else if (step) begin
      acc_q <= {acc_sum[WIDTH], acc_sum[WIDTH:1]};
      q_q   <= {acc_sum[0], q_q[WIDTH-1:1]};
      q1_q  <= q_q[0];
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign last    = (cnt_q == CW'(WIDTH - 1));
  assign product = {acc_q[WIDTH-1:0], q_q};

endmodule

// File: rtl/booth_mul_arbiter.sv
// Round-robin front end sharing one Booth multiplier between NREQ requesters.
module booth_mul_arbiter
  import booth_pkg::*;
#(
  parameter  int unsigned WIDTH = 4,
  parameter  int unsigned NREQ  = 2,
  localparam int unsigned IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [2*WIDTH-1:0]    rsp_data,
  output logic [IDW-1:0]        rsp_id,
  output logic                  busy
);

  state_t           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d, id_q, grant_idx;
  logic             grant_found, accept, last;
  logic [WIDTH-1:0] grant_a, grant_b;
  int unsigned      idx;

  // First valid requester at or after ptr_q, wrapping at NREQ
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (32'(ptr_q) + k) % NREQ;
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_idx   = IDW'(idx);
      end
    end
  end

  assign accept    = (state_q == StIdle) && grant_found;
  assign req_ready = accept ? (NREQ'(1) << grant_idx) : '0;
  assign grant_a   = req_a[32'(grant_idx)*WIDTH +: WIDTH];
  assign grant_b   = req_b[32'(grant_idx)*WIDTH +: WIDTH];
  assign ptr_d     = accept ? IDW'((32'(grant_idx) + 1) % NREQ) : ptr_q;

  // Next-state logic: accept -> WIDTH steps -> hold result until taken
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (accept)    state_d = StRun;
      StRun:   if (last)      state_d = StDone;
      StDone:  if (rsp_ready) state_d = StIdle;
      default:                state_d = StIdle;
    endcase
  end

  // State, arbitration pointer and response tag
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      if (accept) id_q <= grant_idx;
    end
  end

  booth_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk     (clk),
    .n_rst   (n_rst),
    .load    (accept),
    .a       (grant_a),
    .b       (grant_b),
    .step    (state_q == StRun),
    .last    (last),
    .product (rsp_data)
  );

  assign rsp_valid = (state_q == StDone);
  assign rsp_id    = id_q;
  assign busy      = (state_q != StIdle);

endmodule
